// File: rtl/draw_crosshair_param_if.sv
// Start/done handshake plus VGA adapter write port for the crosshair renderer.
// The slave modport belongs to the renderer. The master modport belongs to the frame controller side.
interface draw_crosshair_param_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 18,
    parameter int ARM_W    = 4
);
    logic                start;
    logic [X_W-1:0]      center_x;
    logic [Y_W-1:0]      center_y;
    logic [ARM_W-1:0]    arm_len;
    logic [ARM_W-1:0]    gap;
    logic [COLOUR_W-1:0] colour;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_write;

    modport master (
        output start, center_x, center_y, arm_len, gap, colour,
        input  busy, done, vga_x, vga_y, vga_colour, vga_write
    );

    modport slave (
        input  start, center_x, center_y, arm_len, gap, colour,
        output busy, done, vga_x, vga_y, vga_colour, vga_write
    );
endinterface

// File: rtl/draw_crosshair_param.sv
// Plus-shaped reticle renderer that emits one pixel per cycle, with the centre pixel first and then the up, right, down and left arms.
// Off-screen pixels still consume their cycle but are not written, so draw latency does not depend on position.
module draw_crosshair_param #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 18,
    parameter int ARM_W    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                  clock,
    input  logic                  reset,
    draw_crosshair_param_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CENTER, ARM, DONE} state_t;

    localparam logic [X_W:0]   SW  = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   SH  = (Y_W+1)'(SCREEN_H);
    localparam logic [ARM_W-1:0] ONE = ARM_W'(1);

    state_t              state;
    logic [X_W-1:0]      cx_q;
    logic [Y_W-1:0]      cy_q;
    logic [ARM_W-1:0]    arm_q;
    logic [ARM_W-1:0]    gap_q;
    logic [ARM_W-1:0]    k_q;
    logic [1:0]          dir_q;

    logic                busy_q;
    logic                done_q;
    logic [X_W-1:0]      vga_x_q;
    logic [Y_W-1:0]      vga_y_q;
    logic [COLOUR_W-1:0] vga_colour_q;
    logic                vga_write_q;

    logic [1:0]          nxt_dir;
    logic [ARM_W-1:0]    nxt_k;
    logic                arm_last;
    logic [X_W:0]        bx, kx, px;
    logic [Y_W:0]        by, ky, py;
    logic                pix_ok;

    assign arm_last = (dir_q == 2'd3) && (k_q == arm_q);

    // Position of the pixel that the next edge puts on the outputs.
    always_comb begin
        nxt_dir = dir_q;
        nxt_k   = k_q + ONE;
        if (state == CENTER) begin
            nxt_dir = 2'd0;
            nxt_k   = gap_q + ONE;
        end else if (k_q == arm_q) begin
            nxt_dir = dir_q + 2'd1;
            nxt_k   = gap_q + ONE;
        end
    end

    // The centre pixel comes straight from the inputs because they are latched on the same edge.
    always_comb begin
        bx = {1'b0, (state == IDLE) ? bus.center_x : cx_q};
        by = {1'b0, (state == IDLE) ? bus.center_y : cy_q};
        kx = {{(X_W+1-ARM_W){1'b0}}, nxt_k};
        ky = {{(Y_W+1-ARM_W){1'b0}}, nxt_k};
        px = bx;
        py = by;
        if (state != IDLE) begin
            case (nxt_dir)
                2'd0:    py = by - ky;
                2'd1:    px = bx + kx;
                2'd2:    py = by + ky;
                default: px = bx - kx;
            endcase
        end
        pix_ok = !px[X_W] && (px < SW) && !py[Y_W] && (py < SH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cx_q         <= '0;
            cy_q         <= '0;
            arm_q        <= '0;
            gap_q        <= '0;
            k_q          <= '0;
            dir_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_write_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            vga_write_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= CENTER;
                        cx_q         <= bus.center_x;
                        cy_q         <= bus.center_y;
                        arm_q        <= bus.arm_len;
                        gap_q        <= bus.gap;
                        busy_q       <= 1'b1;
                        vga_colour_q <= bus.colour;
                        if (pix_ok) begin
                            vga_write_q <= 1'b1;
                            vga_x_q     <= px[X_W-1:0];
                            vga_y_q     <= py[Y_W-1:0];
                        end
                    end
                end
                CENTER, ARM: begin
                    if ((state == CENTER && arm_q <= gap_q) || (state == ARM && arm_last)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= ARM;
                        dir_q <= nxt_dir;
                        k_q   <= nxt_k;
                        if (pix_ok) begin
                            vga_write_q <= 1'b1;
                            vga_x_q     <= px[X_W-1:0];
                            vga_y_q     <= py[Y_W-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_write  = vga_write_q;
endmodule

// File: tb/tb_draw_crosshair_param.sv
// Bench for the crosshair renderer: directed scenarios plus random draws checked against a pixel-list model.
module tb_draw_crosshair_param;
    localparam int X_W = 8, Y_W = 7, COLOUR_W = 18, ARM_W = 4;
    localparam int SW = 160, SH = 120;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   last_x, last_y;
    int   last_col;

    draw_crosshair_param_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .ARM_W(ARM_W)) bus ();

    draw_crosshair_param #(
        .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .ARM_W(ARM_W),
        .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_done"},  32'(bus.done), 32'd0);
        chk({tag, "_write"}, 32'(bus.vga_write), 32'd0);
    endtask

    task automatic scramble();
        bus.center_x = X_W'($urandom);
        bus.center_y = Y_W'($urandom);
        bus.arm_len  = ARM_W'($urandom);
        bus.gap      = ARM_W'($urandom);
        bus.colour   = COLOUR_W'($urandom);
    endtask

    // The caller is in cycle T+1 of a draw. The task checks every pixel cycle and then the done cycle.
    task automatic check_draw(input int cx, input int cy, input int arm, input int gp, input int col);
        int  xs[$];
        int  ys[$];
        int  x, y;
        bit  ok;
        xs.push_back(cx);
        ys.push_back(cy);
        for (int d = 0; d < 4; d++) begin
            for (int k = gp + 1; k <= arm; k++) begin
                case (d)
                    0:       begin xs.push_back(cx);     ys.push_back(cy - k); end
                    1:       begin xs.push_back(cx + k); ys.push_back(cy);     end
                    2:       begin xs.push_back(cx);     ys.push_back(cy + k); end
                    default: begin xs.push_back(cx - k); ys.push_back(cy);     end
                endcase
            end
        end
        last_col = col;
        for (int i = 0; i < xs.size(); i++) begin
            if (i > 0) tick();
            x  = xs[i];
            y  = ys[i];
            ok = (x >= 0) && (x < SW) && (y >= 0) && (y < SH);
            if (ok) begin
                last_x = x;
                last_y = y;
            end
            chk($sformatf("pix%0d_busy", i),  32'(bus.busy), 32'd1);
            chk($sformatf("pix%0d_done", i),  32'(bus.done), 32'd0);
            chk($sformatf("pix%0d_write", i), 32'(bus.vga_write), 32'(ok));
            chk($sformatf("pix%0d_x", i),     32'(bus.vga_x), 32'(last_x));
            chk($sformatf("pix%0d_y", i),     32'(bus.vga_y), 32'(last_y));
            chk($sformatf("pix%0d_col", i),   32'(bus.vga_colour), 32'(last_col));
        end
        tick();
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy",  32'(bus.busy), 32'd0);
        chk("done_write", 32'(bus.vga_write), 32'd0);
        chk("done_x",     32'(bus.vga_x), 32'(last_x));
        chk("done_y",     32'(bus.vga_y), 32'(last_y));
    endtask

    task automatic load(input int cx, input int cy, input int arm, input int gp, input int col);
        bus.center_x = X_W'(cx);
        bus.center_y = Y_W'(cy);
        bus.arm_len  = ARM_W'(arm);
        bus.gap      = ARM_W'(gp);
        bus.colour   = COLOUR_W'(col);
    endtask

    task automatic run_draw(input int cx, input int cy, input int arm, input int gp, input int col);
        load(cx, cy, arm, gp, col);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        scramble();
        check_draw(cx, cy, arm, gp, col);
        tick();
        chk_quiet("idle_after");
    endtask

    initial begin
        int cx, cy, arm, gp, col;
        total    = 0;
        bad      = 0;
        last_x   = 0;
        last_y   = 0;
        last_col = 0;
        reset    = 1'b1;
        bus.start = 1'b0;
        load(0, 0, 0, 0, 0);
        tick();
        tick();
        chk_quiet("reset");
        chk("reset_x",   32'(bus.vga_x), 32'd0);
        chk("reset_y",   32'(bus.vga_y), 32'd0);
        chk("reset_col", 32'(bus.vga_colour), 32'd0);
        reset = 1'b0;
        tick();
        chk_quiet("post_reset");

        // These are the basic shapes, with clipping at both screen corners.
        run_draw(80, 60, 1, 0, 'h071C7);
        run_draw(80, 60, 3, 1, 'h2ABCD);
        run_draw(0, 0, 2, 0, 'h11111);
        run_draw(159, 119, 2, 0, 'h3FFFF);
        run_draw(50, 40, 5, 5, 'h00F0F);
        run_draw(50, 40, 2, 9, 'h0F0F0);

        // Start stays high and the inputs change mid-draw. Exactly one draw is done, and the next draw starts at T+8.
        load(80, 60, 1, 0, 'h071C7);
        bus.start = 1'b1;
        tick();
        load(10, 10, 1, 0, 'h12345);
        check_draw(80, 60, 1, 0, 'h071C7);
        tick();
        chk_quiet("restart_gap");
        tick();
        bus.start = 1'b0;
        check_draw(10, 10, 1, 0, 'h12345);
        tick();
        chk_quiet("restart_idle");

        // Reset arrives in the middle of a draw.
        load(80, 60, 3, 1, 'h05555);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("mid_c_x", 32'(bus.vga_x), 32'd80);
        chk("mid_c_y", 32'(bus.vga_y), 32'd60);
        tick();
        chk("mid_u_y", 32'(bus.vga_y), 32'd58);
        tick();
        chk("mid_u2_y", 32'(bus.vga_y), 32'd57);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_quiet("mid_reset");
        chk("mid_reset_x",   32'(bus.vga_x), 32'd0);
        chk("mid_reset_y",   32'(bus.vga_y), 32'd0);
        chk("mid_reset_col", 32'(bus.vga_colour), 32'd0);
        last_x = 0;
        last_y = 0;
        last_col = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_quiet("after_reset");
        end
        run_draw(33, 22, 0, 0, 'h2468A);

        for (int n = 0; n < 40; n++) begin
            cx  = int'($urandom_range(0, 200));
            cy  = int'($urandom_range(0, 127));
            arm = int'($urandom_range(0, 15));
            gp  = int'($urandom_range(0, 15));
            if (n % 3 == 0) gp = int'($urandom_range(0, 2));
            col = int'($urandom_range(0, 262143));
            run_draw(cx, cy, arm, gp, col);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
